hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

- Issue-side companion to the pipeline forwarding unit.
- Sits in the decode (ID) stage and records every in-flight register write from issue until writeback.
- Holds a per-register countdown to the cycle when the result can first be forwarded, and stalls ID while a source or destination is not yet forwardable.
- Forwarding covers every hazard whose count has reached 0. This block covers load-use, multi-cycle and WAW hazards.

## Interface
Parameters:
- LOAD_LAT, 1: bubbles required after a load before a dependent can issue.
- MUL_LAT, 4: bubbles required after a multi-cycle (mult/div) op before a dependent can issue.
- CNT_W, 3: countdown width. Must hold max(LOAD_LAT, MUL_LAT).

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset. Asynchronous, active-low.
- id_valid, input, 1: an instruction is presented in ID this cycle.
- id_src1, input, 5: first source register.
- id_src2, input, 5: second source register.
- id_dest, input, 5: destination register.
- id_regwrite, input, 1: the instruction writes id_dest.
- id_is_load, input, 1: the instruction is a load.
- id_is_mult, input, 1: the instruction is a multi-cycle op. Ignored if id_is_load=1.
- wb_regwrite, input, 1: writeback commits this cycle.
- wb_dest, input, 5: writeback register.
- flush, input, 1: pipeline flush (branch/jump). Synchronous.
- stall, output, 1: hold PC and IF/ID, and inject a bubble into ID/EX.
- busy, output, 32: per-register in-flight flag, for debug and the bench.

## Operation
State per register r (1..31):
- busy[r], 1 bit.
- cnt[r], CNT_W bits.
- Register 0 is never busy. busy[0]=0 and cnt[0]=0 at all times.

stall is combinational from current state and ID inputs. It is 1 iff id_valid=1 and at least one of:
- cnt[id_src1]>0 and id_src1!=0.
- cnt[id_src2]>0 and id_src2!=0.
- id_regwrite=1, id_dest!=0, and cnt[id_dest]>0 (WAW: an older long-latency write must not complete after a younger one).

Issue:
- Occurs at the edge when id_valid=1, stall=0, flush=0, id_regwrite=1, id_dest!=0.
- Sets busy[id_dest]=1.
- Sets cnt[id_dest] to LOAD_LAT for a load, MUL_LAT for a multi-cycle op, 0 otherwise.

Every edge, for each r not being issued:
- If cnt[r]>0, cnt[r] decrements by 1. It saturates at 0 and never wraps.

Writeback:
- wb_regwrite=1 and wb_dest!=0 clears busy[wb_dest] and cnt[wb_dest].
- If issue and writeback target the same register in the same cycle, issue wins: busy stays 1 and cnt loads the new value.

Flush:
- Clears nothing that is already past ID, because older instructions still complete.
- Suppresses the issue in ID that cycle.
- stall output is unaffected by flush.

Reset (rst_n=0, asynchronous):
- All busy=0, all cnt=0.
- stall follows combinationally, so it is 0.
- busy output is 32'h0.
- Reset asserted mid-operation discards all tracking immediately.

## Timing
- stall has zero-cycle latency: combinational from ID inputs and registered state.
- Load issued at edge T with LOAD_LAT=1:
  - A dependent in ID during cycle T..T+1 sees stall=1 for exactly 1 cycle.
  - It then issues at edge T+2, and the forwarding unit supplies the value from MEM/WB.
- Multi-cycle op: a dependent stalls exactly MUL_LAT cycles.
- An ALU op produces cnt=0, so it never stalls and busy alone does not stall.
- Countdown is independent of writeback timing. Writeback only clears.
- While stall=1, the ID inputs are held stable by the pipeline and no issue occurs.

## Test plan
1. Reset check: drive rst_n=0 asynchronously mid-cycle -> busy=32'h0 and stall=0 immediately, with no clock edge needed.
2. Load-use: issue lw to $8, then add $9,$8,$10 -> stall=1 for exactly 1 cycle, add issues on the next edge, busy[8]=1 until wb_dest=8.
3. Multi-cycle, MUL_LAT=4: issue mult to $5, then a consumer of $5 -> stall=1 for 4 consecutive cycles, then 0.
4. WAW: issue mult to $3, then add $3,$1,$2 (no source on $3) -> stall=1 for 4 cycles.
5. Register 0: lw $0, then a use of $0 as a source -> stall never asserts and busy[0] stays 0.
6. Same-cycle writeback and issue on $7: an older $7 write commits while lw $7 issues -> busy[7]=1 and cnt[7]=1 afterwards. A dependent then stalls 1 cycle. Asserting flush on a stalled cycle -> no issue recorded.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage tracker of in-flight register writes.
// Stalls ID until every source and destination is forwardable.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic [4:0]  id_dest,
    input  logic        id_regwrite,
    input  logic        id_is_load,
    input  logic        id_is_mult,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_dest,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] busy
);

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [31:0]            busy_q, busy_d;
    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;

    logic src1_haz, src2_haz, waw_haz, issue;

    // Hazard detection: any operand still counting down blocks issue
    always_comb begin
        src1_haz = (id_src1 != 5'd0) && (cnt_q[id_src1] != '0);
        src2_haz = (id_src2 != 5'd0) && (cnt_q[id_src2] != '0);
        waw_haz  = id_regwrite && (id_dest != 5'd0)
                   && (cnt_q[id_dest] != '0);
        stall    = id_valid && (src1_haz || src2_haz || waw_haz);
        issue    = id_valid && !stall && !flush && id_regwrite
                   && (id_dest != 5'd0);
    end

    // Next state: countdown, then writeback clear, then issue (issue wins)
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        for (int r = 0; r < 32; r++) begin
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - ONE;
            end
        end
        if (wb_regwrite && (wb_dest != 5'd0)) begin
            busy_d[wb_dest] = 1'b0;
            cnt_d[wb_dest]  = '0;
        end
        if (issue) begin
            busy_d[id_dest] = 1'b1;
            if (id_is_load) begin
                cnt_d[id_dest] = LOAD_CNT;
            end else if (id_is_mult) begin
                cnt_d[id_dest] = MUL_CNT;
            end else begin
                cnt_d[id_dest] = '0;
            end
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
    end

    // State registers; reset drops all tracking immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, async reset check,
// then random traffic against a reference model.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_src1, id_src2, id_dest;
    logic        id_regwrite, id_is_load, id_is_mult;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic        flush;
    logic        stall;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .LOAD_LAT(LOAD_LAT),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_dest    (id_dest),
        .id_regwrite(id_regwrite),
        .id_is_load (id_is_load),
        .id_is_mult (id_is_mult),
        .wb_regwrite(wb_regwrite),
        .wb_dest    (wb_dest),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  s1, s2, d;
        logic        rw, ld, ml;
        logic        wbw;
        logic [4:0]  wbd;
        logic        fl;
        logic        est;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic v, int s1, int s2, int d, logic rw, logic ld, logic ml,
        logic wbw, int wbd, logic fl, logic est, logic [31:0] eb);
        vec_t t;
        t.v = v; t.s1 = 5'(s1); t.s2 = 5'(s2); t.d = 5'(d);
        t.rw = rw; t.ld = ld; t.ml = ml;
        t.wbw = wbw; t.wbd = 5'(wbd); t.fl = fl;
        t.est = est; t.eb = eb;
        return t;
    endfunction

    function automatic logic [31:0] bm(int a, int b = 0, int c = 0,
                                       int d = 0, int e = 0);
        logic [31:0] m;
        m = '0;
        if (a != 0) m[a] = 1'b1;
        if (b != 0) m[b] = 1'b1;
        if (c != 0) m[c] = 1'b1;
        if (d != 0) m[d] = 1'b1;
        if (e != 0) m[e] = 1'b1;
        return m;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        id_valid    = t.v;
        id_src1     = t.s1;
        id_src2     = t.s2;
        id_dest     = t.d;
        id_regwrite = t.rw;
        id_is_load  = t.ld;
        id_is_mult  = t.ml;
        wb_regwrite = t.wbw;
        wb_dest     = t.wbd;
        flush       = t.fl;
    endtask

    // Reference model state
    int mc[32];
    bit mb[32];

    function automatic bit m_stall();
        bit h;
        h = (id_src1 != 0 && mc[id_src1] > 0)
         || (id_src2 != 0 && mc[id_src2] > 0)
         || (id_regwrite && id_dest != 0 && mc[id_dest] > 0);
        return id_valid && h;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = mb[r];
        return b;
    endfunction

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lw $8 ; add $9,$8,$10 ; wb $8
        tbl.push_back(mk(1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 10, 9, 1, 0, 0, 0, 0, 0, 1, bm(8)));
        tbl.push_back(mk(1, 8, 10, 9, 1, 0, 0, 0, 0, 0, 0, bm(8)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, bm(8, 9)));
        // mult $5 ; add $6,$5,$0 stalls 4
        tbl.push_back(mk(1, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, bm(9)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 1, bm(5, 9)));
        tbl.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, bm(5, 9)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, bm(5, 6, 9)));
        // WAW: mult $3 ; add $3,$1,$2 stalls 4
        tbl.push_back(mk(1, 1, 2, 3, 1, 0, 1, 0, 0, 0, 0, bm(6, 9)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 1, bm(3, 6, 9)));
        tbl.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, bm(3, 6, 9)));
        // lw $0 ; add $11,$0,$0 never stalls
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, bm(3, 6, 9)));
        tbl.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, bm(3, 6, 9)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         bm(3, 6, 9, 11)));
        // add $7 ; lw $7 with wb $7 same edge ; dependent stalls 1
        tbl.push_back(mk(1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,
                         bm(3, 6, 9, 11)));
        tbl.push_back(mk(1, 0, 0, 7, 1, 1, 0, 1, 7, 0, 0,
                         bm(3, 6, 7, 9, 11)));
        tbl.push_back(mk(1, 7, 0, 12, 1, 0, 0, 0, 0, 1, 1,
                         bm(3, 6, 7, 9, 11)));
        // flush on the now-clear cycle suppresses the issue of $12
        tbl.push_back(mk(1, 7, 0, 12, 1, 0, 0, 0, 0, 1, 0,
                         bm(3, 6, 7, 9, 11)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         bm(3, 6, 7, 9, 11)));

        rst_n = 1'b1;
        drive(idle);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].est));
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
            @(posedge clk);
            #1;
        end

        // Async reset while a consumer is stalled on a mult
        drive(mk(1, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("pre_rst_stall", 32'(stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'h0);
        chk("mid_rst_busy", busy, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            mc[r] = 0;
            mb[r] = 1'b0;
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit ms, iss;
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src1     = 5'($urandom_range(0, 7));
            id_src2     = 5'($urandom_range(0, 7));
            id_dest     = 5'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            id_is_mult  = ($urandom_range(0, 3) == 0);
            wb_regwrite = ($urandom_range(0, 2) == 0);
            wb_dest     = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            ms = m_stall();
            chk("rand_stall", 32'(stall), 32'(ms));
            chk("rand_busy", busy, m_busy());
            iss = id_valid && !ms && !flush && id_regwrite && id_dest != 0;
            for (int r = 0; r < 32; r++)
                if (mc[r] > 0) mc[r] = mc[r] - 1;
            if (wb_regwrite && wb_dest != 0) begin
                mc[wb_dest] = 0;
                mb[wb_dest] = 1'b0;
            end
            if (iss) begin
                mb[id_dest] = 1'b1;
                mc[id_dest] = id_is_load ? LOAD_LAT
                            : id_is_mult ? MUL_LAT : 0;
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
